// File: rtl/cmp_bus_ctrl.sv
// CPU-to-component bus bridge: serialises a CPU access into one or two byte
// strobes, then waits for the component's ack with a bounded timeout.
module cmp_bus_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdy,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic [2:0]  cmp_sel,
    output logic [7:0]  cmp_addr,
    output logic [7:0]  cmp_byte,
    output logic        cmp_strobe,
    output logic        cmp_we,
    input  logic        cmp_rdy,
    input  logic [31:0] cmp_data
);

    typedef enum logic [2:0] {IDLE, SEND0, SEND1, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

    state_t      state_q;
    logic [11:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        rdy_q, busy_q, err_q;
    logic [2:0]  sel_q;
    logic [7:0]  byte_q;
    logic        strobe_q, cwe_q;

    // Outputs are all registered: each is loaded on the edge entering the
    // state in which it must be visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            byte_q   <= '0;
            strobe_q <= 1'b0;
            cwe_q    <= 1'b0;
        end else begin
            rdy_q    <= 1'b0;
            strobe_q <= 1'b0;
            cwe_q    <= 1'b0;
            byte_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        we_q     <= cpu_we;
                        err_q    <= 1'b0;
                        sel_q    <= (cpu_addr[11:8] == 4'd0) ? 3'd2 : 3'd3;
                        strobe_q <= 1'b1;
                        cwe_q    <= cpu_we;
                        byte_q   <= cpu_we ? cpu_wdata[7:0] : 8'h00;
                        busy_q   <= 1'b1;
                        state_q  <= SEND0;
                    end
                end
                SEND0: begin
                    if (we_q) begin
                        strobe_q <= 1'b1;
                        cwe_q    <= 1'b1;
                        byte_q   <= wdata_q[15:8];
                        state_q  <= SEND1;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                SEND1: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // An ack on the timeout cycle takes priority over the abort.
                    if (cmp_rdy) begin
                        if (!we_q) rdata_q <= cmp_data;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        if (!we_q) rdata_q <= '0;
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_rdy    = rdy_q;
    assign cpu_busy   = busy_q;
    assign cpu_err    = err_q;
    assign cmp_sel    = sel_q;
    assign cmp_addr   = addr_q[7:0];
    assign cmp_byte   = byte_q;
    assign cmp_strobe = strobe_q;
    assign cmp_we     = cwe_q;

endmodule

// File: tb/tb_cmp_bus_ctrl.sv
// Scoreboard bench for cmp_bus_ctrl: the driver pushes the expected outcome of
// each transaction, a negedge monitor checks the bus and pops on cpu_rdy.
module tb_cmp_bus_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_rdy, cpu_busy, cpu_err;
    logic [2:0]  cmp_sel;
    logic [7:0]  cmp_addr, cmp_byte;
    logic        cmp_strobe, cmp_we;
    logic        cmp_rdy = 1'b0;
    logic [31:0] cmp_data = '0;

    cmp_bus_ctrl #(.TIMEOUT(8'd255)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
        .cmp_sel(cmp_sel), .cmp_addr(cmp_addr), .cmp_byte(cmp_byte),
        .cmp_strobe(cmp_strobe), .cmp_we(cmp_we), .cmp_rdy(cmp_rdy), .cmp_data(cmp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          abort;
        logic [2:0]  sel;
        logic [7:0]  addr;
        logic [7:0]  b0, b1;
        int          lat;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [31:0] mdl_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {8'd0, cpu_rdata, cpu_rdy, cpu_busy, cpu_err, cmp_sel, cmp_addr,
                cmp_byte, cmp_strobe, cmp_we};
    endfunction

    // d = WAIT-cycle index of the ack, -1 for no ack (timeout).
    // Called at 1 time unit after a rising edge.
    task automatic do_txn(input bit we, input logic [11:0] addr, input logic [15:0] wd,
                          input int d, input logic [31:0] adata, input bit noise,
                          input int abort_at);
        exp_t e;
        int nsend, lat, widx;
        nsend = we ? 2 : 1;
        lat   = nsend + ((d < 0) ? TO : d + 1) + 1;
        e.we = we; e.abort = (abort_at > 0);
        e.sel = (addr[11:8] == 4'd0) ? 3'd2 : 3'd3;
        e.addr = addr[7:0];
        e.b0 = we ? wd[7:0] : 8'h00;
        e.b1 = wd[15:8];
        e.lat = lat;
        e.err = (d < 0);
        if (!we) mdl_rdata = (d < 0) ? 32'h0 : adata;
        e.rdata = mdl_rdata;
        sb.push_back(e);

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cmp_rdy = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= lat; k++) begin
            if (k == abort_at) begin
                chk("busy_before_rst", cpu_busy, 1);
                #1 rst = 1'b1;
                #1 chk("async_reset_outs", all_outs(), 0);
                cpu_req = 1'b0; cmp_rdy = 1'b0;
                mdl_rdata = '0;
                @(posedge clk); @(posedge clk); #1 rst = 1'b0;
                return;
            end
            cpu_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cpu_we    = noise ? 1'($urandom_range(0, 1)) : we;
            cpu_addr  = noise ? 12'($urandom) : addr;
            cpu_wdata = noise ? 16'($urandom) : wd;
            widx = k - nsend - 1;
            if (widx == d && d >= 0) begin
                cmp_rdy = 1'b1; cmp_data = adata;
            end else begin
                cmp_data = $urandom;
                if (widx < 0 || widx > ((d < 0) ? TO - 1 : d))
                    cmp_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                else
                    cmp_rdy = 1'b0;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; cmp_rdy = 1'b0;
    endtask

    // Monitor
    initial begin
        int busy_cnt, nstb;
        logic [7:0] bytes [2];
        exp_t e;
        busy_cnt = 0; nstb = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sb.size() > 0 && sb[0].abort) void'(sb.pop_front());
                busy_cnt = 0; nstb = 0;
            end else if (cpu_busy) begin
                busy_cnt++;
                if (sb.size() == 0) begin
                    chk("busy_without_txn", cpu_busy, 0);
                end else begin
                    e = sb[0];
                    if (busy_cnt == 1) chk("err_cleared_on_accept", cpu_err, 0);
                    chk("cmp_sel", cmp_sel, e.sel);
                    chk("cmp_addr", cmp_addr, e.addr);
                    if (cmp_strobe) begin
                        chk("strobe_we", cmp_we, e.we);
                        if (nstb < 2) bytes[nstb] = cmp_byte;
                        nstb++;
                    end else begin
                        chk("quiet_we_byte", {cmp_we, cmp_byte}, 0);
                    end
                    if (cpu_rdy) begin
                        if (e.abort) chk("rdy_on_aborted", cpu_rdy, 0);
                        chk("latency", busy_cnt, e.lat);
                        chk("rdata", cpu_rdata, e.rdata);
                        chk("err", cpu_err, e.err);
                        chk("num_strobes", nstb, e.we ? 2 : 1);
                        chk("byte0", bytes[0], e.b0);
                        if (e.we) chk("byte1", bytes[1], e.b1);
                        void'(sb.pop_front());
                        busy_cnt = 0; nstb = 0;
                    end
                end
            end else begin
                chk("idle_quiet", {cpu_rdy, cmp_strobe, cmp_we, cmp_byte}, 0);
            end
        end
    end

    // Driver
    initial begin
        bit we; int d;
        logic [11:0] a;
        #1 chk("reset_outs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, 12'h034, 16'h0000, 0, 32'hDEADBEEF, 1'b0, 0);
        do_txn(1'b1, 12'h1A0, 16'hBEEF, 1, 32'h12345678, 1'b0, 0);
        do_txn(1'b0, 12'h055, 16'h0000, -1, 32'h0, 1'b0, 0);
        do_txn(1'b0, 12'h2C1, 16'h0000, 0, 32'hCAFEF00D, 1'b0, 0);
        do_txn(1'b0, 12'h077, 16'h0000, TO - 1, 32'hA5A55A5A, 1'b0, 0);
        do_txn(1'b1, 12'h0F0, 16'h1234, -1, 32'h0, 1'b0, 0);
        do_txn(1'b1, 12'h301, 16'h5AA5, 2, 32'h0, 1'b1, 0);
        do_txn(1'b0, 12'h010, 16'h0000, 1, 32'h600DCAFE, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 12'($urandom);
            if ($urandom_range(0, 1) == 0) a[11:8] = 4'd0;
            d  = $urandom_range(0, 6);
            do_txn(we, a, 16'($urandom), d, $urandom, 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        // Reset in the WAIT phase of a read, then a normal read right after release.
        do_txn(1'b0, 12'h123, 16'h0000, -1, 32'h0, 1'b0, 4);
        do_txn(1'b0, 12'h034, 16'h0000, 0, 32'h0BADF00D, 1'b0, 0);

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
